// File: rtl/carpark_occupancy_ctrl_pkg.sv
// Shared types, defaults and helpers for the multi-lane car park occupancy controller.
package carpark_pkg;

  localparam int DEF_N_LANES  = 2;
  localparam int DEF_CAPACITY = 99;
  localparam int DEF_CNT_W    = 7;

  typedef enum logic [2:0] {
    IDLE,
    E1,
    E2,
    E3,
    X1,
    X2,
    X3
  } lane_state_t;

  // Sized for the widest supported build (8 lanes); narrower vectors are zero-extended.
  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/carpark_occupancy_ctrl_if.sv
// Sensor, status and event signals between the lane debouncers, the controller and the display side.
interface carpark_occupancy_ctrl_if #(
  parameter int N_LANES = 2,
  parameter int CNT_W   = 7
);
  logic [N_LANES-1:0] sens_a;
  logic [N_LANES-1:0] sens_b;
  logic               flag_clr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic [N_LANES-1:0] enter_pulse;
  logic [N_LANES-1:0] exit_pulse;
  logic               enter_flag;
  logic               exit_flag;
  logic               reject_flag;

  modport master (
    output sens_a, sens_b, flag_clr,
    input  count, full, empty, enter_pulse, exit_pulse,
    input  enter_flag, exit_flag, reject_flag
  );

  modport slave (
    input  sens_a, sens_b, flag_clr,
    output count, full, empty, enter_pulse, exit_pulse,
    output enter_flag, exit_flag, reject_flag
  );
endinterface

// File: rtl/carpark_occupancy_ctrl_lane_fsm.sv
// One gate lane: tracks the outer/inner sensor pair and emits a registered
// one-cycle pulse when a full entry or exit passage completes.
module carpark_lane_fsm
  import carpark_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter_pulse,
  output logic exit_pulse
);

  lane_state_t state_q, state_d;
  logic        enter_pulse_q, enter_pulse_d;
  logic        exit_pulse_q, exit_pulse_d;
  logic [1:0]  ab;

  assign ab = {a, b};

  always_comb begin
    state_d       = state_q;
    enter_pulse_d = 1'b0;
    exit_pulse_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ab == 2'b10)      state_d = E1;
        else if (ab == 2'b01) state_d = X1;
      end
      E1: begin
        if (ab == 2'b11)      state_d = E2;
        else if (ab != 2'b10) state_d = IDLE;
      end
      E2: begin
        case (ab)
          2'b01:   state_d = E3;
          2'b10:   state_d = E1;
          2'b11:   state_d = E2;
          default: state_d = IDLE;
        endcase
      end
      E3: begin
        case (ab)
          2'b00: begin
            state_d       = IDLE;
            enter_pulse_d = 1'b1;
          end
          2'b11:   state_d = E2;
          2'b01:   state_d = E3;
          default: state_d = IDLE;
        endcase
      end
      X1: begin
        if (ab == 2'b11)      state_d = X2;
        else if (ab != 2'b01) state_d = IDLE;
      end
      X2: begin
        case (ab)
          2'b10:   state_d = X3;
          2'b01:   state_d = X1;
          2'b11:   state_d = X2;
          default: state_d = IDLE;
        endcase
      end
      X3: begin
        case (ab)
          2'b00: begin
            state_d      = IDLE;
            exit_pulse_d = 1'b1;
          end
          2'b11:   state_d = X2;
          2'b10:   state_d = X3;
          default: state_d = IDLE;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      enter_pulse_q <= 1'b0;
      exit_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      enter_pulse_q <= enter_pulse_d;
      exit_pulse_q  <= exit_pulse_d;
    end
  end

  assign enter_pulse = enter_pulse_q;
  assign exit_pulse  = exit_pulse_q;

endmodule

// File: rtl/carpark_occupancy_ctrl.sv
// Multi-lane car park occupancy controller: per-lane passage FSMs feeding one
// saturating occupancy counter with full/empty status and sticky event flags.
module carpark_occupancy_ctrl
  import carpark_pkg::*;
#(
  parameter int N_LANES  = DEF_N_LANES,
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  carpark_occupancy_ctrl_if.slave  bus
);

  localparam logic signed [CNT_W+3:0] CAP_S = (CNT_W+4)'(CAPACITY);
  localparam logic        [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

  logic [N_LANES-1:0] enter_pulse;
  logic [N_LANES-1:0] exit_pulse;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    carpark_lane_fsm u_lane (
      .clk         (clk),
      .reset       (reset),
      .a           (bus.sens_a[i]),
      .b           (bus.sens_b[i]),
      .enter_pulse (enter_pulse[i]),
      .exit_pulse  (exit_pulse[i])
    );
  end

  logic [7:0]              enter_ext, exit_ext;
  logic [3:0]              n_in, n_out;
  logic signed [CNT_W+3:0] sum;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    enter_flag_q, enter_flag_d;
  logic                    exit_flag_q, exit_flag_d;
  logic                    reject_flag_q, reject_flag_d;
  logic                    reject_set;

  always_comb begin
    enter_ext                = '0;
    exit_ext                 = '0;
    enter_ext[N_LANES-1:0]   = enter_pulse;
    exit_ext[N_LANES-1:0]    = exit_pulse;
    n_in  = popcount(enter_ext);
    n_out = popcount(exit_ext);
    // Entries and exits net out first; only the net result is clamped.
    sum = signed'({4'b0000, count_q})
        + signed'({{CNT_W{1'b0}}, n_in})
        - signed'({{CNT_W{1'b0}}, n_out});
    reject_set = 1'b0;
    if (sum > CAP_S) begin
      count_d    = CAP_C;
      reject_set = 1'b1;
    end else if (sum < 0) begin
      count_d    = '0;
      reject_set = 1'b1;
    end else begin
      count_d = sum[CNT_W-1:0];
    end
    enter_flag_d  = (n_in != 4'd0)  | (enter_flag_q  & ~bus.flag_clr);
    exit_flag_d   = (n_out != 4'd0) | (exit_flag_q   & ~bus.flag_clr);
    reject_flag_d = reject_set      | (reject_flag_q & ~bus.flag_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      enter_flag_q  <= 1'b0;
      exit_flag_q   <= 1'b0;
      reject_flag_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      enter_flag_q  <= enter_flag_d;
      exit_flag_q   <= exit_flag_d;
      reject_flag_q <= reject_flag_d;
    end
  end

  assign bus.count       = count_q;
  assign bus.full        = (count_q == CAP_C);
  assign bus.empty       = (count_q == '0);
  assign bus.enter_pulse = enter_pulse;
  assign bus.exit_pulse  = exit_pulse;
  assign bus.enter_flag  = enter_flag_q;
  assign bus.exit_flag   = exit_flag_q;
  assign bus.reject_flag = reject_flag_q;

endmodule
